// File: rtl/sprite_pkg.sv
// Shared sprite constants: attribute layout, pattern geometry and the line engine states.
package sprite_pkg;

    localparam logic [2:0] ATTR_X_LO    = 3'd0;
    localparam logic [2:0] ATTR_FLAGS   = 3'd1;
    localparam logic [2:0] ATTR_Y_LO    = 3'd2;
    localparam logic [2:0] ATTR_Y_HI    = 3'd3;
    localparam logic [2:0] ATTR_PATTERN = 3'd4;
    localparam logic [2:0] ATTR_PALETTE = 3'd5;

    localparam int unsigned FLAG_EN    = 7;
    localparam int unsigned FLAG_HFLIP = 6;
    localparam int unsigned FLAG_VFLIP = 5;

    localparam int unsigned SPR_BYTES_PER_SLOT    = 8;
    localparam int unsigned SPR_BYTES_PER_PATTERN = 128;
    localparam int unsigned SPR_BYTES_PER_ROW     = 8;
    localparam int unsigned SPR_ROWS              = 16;

    typedef enum logic [2:0] {
        StIdle, StClear, StScan, StEval, StFetch, StDraw, StNext, StDone
    } sle_state_e;

endpackage

// File: rtl/sprite_row_unpack.sv
// Splits a 4bpp pattern byte into two pixels; holds the byte for the second pixel.
module sprite_row_unpack #(
    parameter int unsigned LINE_WIDTH = 320
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] gfx_byte,
    input  logic       hflip,
    input  logic       phase,
    input  logic [8:0] x,
    output logic [3:0] colour,
    output logic       write_ok
);

    logic [7:0] byte_q;
    logic [7:0] cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q <= 8'd0;
        end else if (load) begin
            byte_q <= gfx_byte;
        end
    end

    // Phase 0 sees the byte straight off the RAM; phase 1 uses the held copy.
    always_comb begin
        cur      = phase ? byte_q : gfx_byte;
        colour   = (phase ^ hflip) ? cur[3:0] : cur[7:4];
        write_ok = (colour != 4'd0) && (32'(x) < LINE_WIDTH);
    end

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite compositor: clears the line buffer, then draws hit sprites slot 127..0.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = 320,
    parameter int unsigned MAX_PER_LINE = 16,
    parameter int unsigned NUM_SPRITES  = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  line_num,
    input  logic        sprites_en,
    output logic [9:0]  attr_addr,
    input  logic [7:0]  attr_data,
    output logic [13:0] gfx_addr,
    input  logic [7:0]  gfx_data,
    output logic [8:0]  lb_addr,
    output logic [7:0]  lb_data,
    output logic        lb_we,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned   CW        = $clog2(MAX_PER_LINE + 1);
    localparam logic [6:0]    LAST_SLOT = 7'(NUM_SPRITES - 1);
    localparam logic [8:0]    LAST_X    = 9'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PER_LINE);

    sle_state_e    state_q;
    logic [8:0]    line_q, clr_x_q;
    logic [6:0]    slot_q;
    logic [2:0]    k_q;
    logic [3:0]    pix_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [8:0]    spr_x_q, spr_y_q;
    logic          spr_en_q, spr_hf_q, spr_vf_q;
    logic [6:0]    spr_pat_q;
    logic [3:0]    spr_pal_q;

    logic [8:0] row, draw_x;
    logic [3:0] r, px_colour;
    logic [2:0] j, byte_sel, attr_idx;
    logic       hit, px_ok;

    always_comb begin
        row      = line_q - spr_y_q;
        hit      = spr_en_q && (row < 9'(SPR_ROWS));
        r        = spr_vf_q ? 4'd15 - row[3:0] : row[3:0];
        // Byte j+1 is addressed on odd pixels so it arrives for the next even pixel.
        j        = pix_q[3:1] + {2'b00, pix_q[0]};
        byte_sel = spr_hf_q ? 3'd7 - j : j;
        draw_x   = spr_x_q + {5'd0, pix_q};
        attr_idx = k_q - 3'd1;
        attr_addr = 10'(32'(slot_q) * SPR_BYTES_PER_SLOT + 32'(k_q));
        gfx_addr  = 14'(32'(spr_pat_q) * SPR_BYTES_PER_PATTERN
                        + 32'(r) * SPR_BYTES_PER_ROW + 32'(byte_sel));
    end

    sprite_row_unpack #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_unpack (
        .clk      (clk),
        .reset    (reset),
        .load     ((state_q == StDraw) && !pix_q[0]),
        .gfx_byte (gfx_data),
        .hflip    (spr_hf_q),
        .phase    (pix_q[0]),
        .x        (draw_x),
        .colour   (px_colour),
        .write_ok (px_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            line_q    <= 9'd0;
            clr_x_q   <= 9'd0;
            slot_q    <= 7'd0;
            k_q       <= 3'd0;
            pix_q     <= 4'd0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            spr_x_q   <= 9'd0;
            spr_y_q   <= 9'd0;
            spr_en_q  <= 1'b0;
            spr_hf_q  <= 1'b0;
            spr_vf_q  <= 1'b0;
            spr_pat_q <= 7'd0;
            spr_pal_q <= 4'd0;
            lb_addr   <= 9'd0;
            lb_data   <= 8'd0;
            lb_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else if (line_start) begin
            // Also aborts a running job: no done pulse, overflow output untouched.
            state_q <= StClear;
            line_q  <= line_num;
            clr_x_q <= 9'd0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            lb_we   <= 1'b0;
        end else begin
            lb_we <= 1'b0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: ;
                StClear: begin
                    lb_we   <= 1'b1;
                    lb_addr <= clr_x_q;
                    lb_data <= 8'd0;
                    clr_x_q <= clr_x_q + 9'd1;
                    if (clr_x_q == LAST_X) begin
                        slot_q  <= LAST_SLOT;
                        k_q     <= 3'd0;
                        state_q <= sprites_en ? StScan : StDone;
                    end
                end
                StScan: begin
                    if (k_q != 3'd0) begin
                        case (attr_idx)
                            ATTR_X_LO: spr_x_q[7:0] <= attr_data;
                            ATTR_FLAGS: begin
                                spr_en_q   <= attr_data[FLAG_EN];
                                spr_hf_q   <= attr_data[FLAG_HFLIP];
                                spr_vf_q   <= attr_data[FLAG_VFLIP];
                                spr_x_q[8] <= attr_data[0];
                            end
                            ATTR_Y_LO:    spr_y_q[7:0] <= attr_data;
                            ATTR_Y_HI:    spr_y_q[8]   <= attr_data[0];
                            ATTR_PATTERN: spr_pat_q    <= attr_data[6:0];
                            ATTR_PALETTE: spr_pal_q    <= attr_data[3:0];
                            default: ;
                        endcase
                    end
                    k_q <= k_q + 3'd1;
                    if (k_q == 3'd6) state_q <= StEval;
                end
                StEval: begin
                    if (!hit) begin
                        state_q <= StNext;
                    end else if (count_q == MAX_CNT) begin
                        ovf_q   <= 1'b1;
                        state_q <= StNext;
                    end else begin
                        count_q <= count_q + 1'b1;
                        pix_q   <= 4'd0;
                        state_q <= StFetch;
                    end
                end
                StFetch: state_q <= StDraw;
                StDraw: begin
                    lb_we   <= px_ok;
                    lb_addr <= draw_x;
                    lb_data <= {spr_pal_q, px_colour};
                    pix_q   <= pix_q + 4'd1;
                    if (pix_q == 4'd15) state_q <= StNext;
                end
                StNext: begin
                    if (slot_q == 7'd0) begin
                        state_q <= StDone;
                    end else begin
                        slot_q  <= slot_q - 7'd1;
                        k_q     <= 3'd0;
                        state_q <= StScan;
                    end
                end
                StDone: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    overflow <= ovf_q;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench: RAM models, line-buffer capture and a pixel-level reference model.
module tb_sprite_line_engine;

    logic        clk = 1'b0;
    logic        reset, line_start, sprites_en;
    logic [8:0]  line_num;
    logic [9:0]  attr_addr;
    logic [7:0]  attr_data;
    logic [13:0] gfx_addr;
    logic [7:0]  gfx_data;
    logic [8:0]  lb_addr;
    logic [7:0]  lb_data;
    logic        lb_we, busy, done, overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] attr_mem [1024];
    logic [7:0] gfx_mem [16384];
    logic [7:0] lbuf [512];
    int         lb_epoch [512];
    logic [7:0] exp_lb [320];
    int         exp_wr;
    bit         exp_ovf;
    int         job_id = 0;
    int         wr_total = 0, done_total = 0, bad_total = 0;

    always #5 clk = ~clk;

    sprite_line_engine dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line_num   (line_num),
        .sprites_en (sprites_en),
        .attr_addr  (attr_addr),
        .attr_data  (attr_data),
        .gfx_addr   (gfx_addr),
        .gfx_data   (gfx_data),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .lb_we      (lb_we),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always @(posedge clk) begin
        attr_data <= attr_mem[attr_addr];
        gfx_data  <= gfx_mem[gfx_addr];
    end

    always @(negedge clk) begin
        if (lb_we === 1'b1) begin
            wr_total++;
            if (lb_addr >= 9'd320) bad_total++;
            lbuf[lb_addr]     = lb_data;
            lb_epoch[lb_addr] = job_id;
        end
        if (done === 1'b1) done_total++;
    end

    task automatic clear_attrs();
        for (int i = 0; i < 1024; i++) attr_mem[i] = 8'd0;
    endtask

    task automatic set_sprite(input int slot, input logic [8:0] x, input logic [8:0] y,
                              input bit en, input bit hf, input bit vf,
                              input logic [6:0] pat, input logic [3:0] pal);
        attr_mem[slot*8 + 0] = x[7:0];
        attr_mem[slot*8 + 1] = {en, hf, vf, 4'b0000, x[8]};
        attr_mem[slot*8 + 2] = y[7:0];
        attr_mem[slot*8 + 3] = {7'd0, y[8]};
        attr_mem[slot*8 + 4] = {1'b0, pat};
        attr_mem[slot*8 + 5] = {4'd0, pal};
        attr_mem[slot*8 + 6] = 8'($urandom);
        attr_mem[slot*8 + 7] = 8'($urandom);
    endtask

    // Reference: walk sprites in priority order and paint pixels straight from the pattern.
    task automatic build_model(input logic [8:0] ln, input bit en);
        int hits, b, sx, sy, row, src_row, p, x;
        bit e, hf, vf;
        logic [7:0] bt;
        logic [3:0] nib;
        for (int i = 0; i < 320; i++) exp_lb[i] = 8'd0;
        exp_wr  = 320;
        exp_ovf = 1'b0;
        hits    = 0;
        if (!en) return;
        for (int s = 127; s >= 0; s--) begin
            b   = s * 8;
            e   = attr_mem[b+1][7];
            hf  = attr_mem[b+1][6];
            vf  = attr_mem[b+1][5];
            sx  = int'(attr_mem[b]) + (attr_mem[b+1][0] ? 256 : 0);
            sy  = int'(attr_mem[b+2]) + (attr_mem[b+3][0] ? 256 : 0);
            row = (int'(ln) - sy + 512) % 512;
            if (!e || row >= 16) continue;
            if (hits == 16) begin
                exp_ovf = 1'b1;
                continue;
            end
            hits++;
            src_row = vf ? 15 - row : row;
            for (int i = 0; i < 16; i++) begin
                p   = hf ? 15 - i : i;
                bt  = gfx_mem[int'(attr_mem[b+4][6:0]) * 128 + src_row * 8 + p / 2];
                nib = (p % 2 == 0) ? bt[7:4] : bt[3:0];
                x   = (sx + i) % 512;
                if (nib != 4'd0 && x < 320) begin
                    exp_lb[x] = {attr_mem[b+5][3:0], nib};
                    exp_wr++;
                end
            end
        end
    endtask

    task automatic start_job(input logic [8:0] ln, input bit en);
        line_num   = ln;
        sprites_en = en;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (done !== 1'b1 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, c);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_job(input string name, input int wr0, input int dn0, input int bad0);
        int mism = 0;
        int first = -1;
        for (int x = 0; x < 320; x++) begin
            if (lb_epoch[x] != job_id || lbuf[x] !== exp_lb[x]) begin
                mism++;
                if (first < 0) first = x;
            end
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL %s pixels: %0d wrong, first x=%0d got %h (job %0d) required %h",
                     name, mism, first, lbuf[first], lb_epoch[first], exp_lb[first]);
        end
        checks++;
        if (wr_total - wr0 != exp_wr) begin
            failures++;
            $display("FAIL %s writes: got %0d required %0d", name, wr_total - wr0, exp_wr);
        end
        checks++;
        if (done_total - dn0 != 1) begin
            failures++;
            $display("FAIL %s done pulses: got %0d required 1", name, done_total - dn0);
        end
        checks++;
        if (bad_total != bad0) begin
            failures++;
            $display("FAIL %s offscreen writes: got %0d required 0", name, bad_total - bad0);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            failures++;
            $display("FAIL %s overflow: got %b required %b", name, overflow, exp_ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy after done: got %b required 0", name, busy);
        end
    endtask

    task automatic run_job(input string name, input logic [8:0] ln, input bit en);
        int wr0, dn0, bad0;
        build_model(ln, en);
        job_id++;
        wr0  = wr_total;
        dn0  = done_total;
        bad0 = bad_total;
        start_job(ln, en);
        wait_done(name);
        check_job(name, wr0, dn0, bad0);
    endtask

    task automatic test_reset();
        checks++;
        if ({attr_addr, gfx_addr, lb_addr, lb_data, lb_we, busy, done, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%h/%h/%h we=%b busy=%b done=%b ovf=%b required all 0",
                     attr_addr, gfx_addr, lb_addr, lb_data, lb_we, busy, done, overflow);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lb_we, busy, done, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_outputs: got we=%b busy=%b done=%b ovf=%b required 0000",
                     lb_we, busy, done, overflow);
        end
    endtask

    task automatic test_clear_only();
        clear_attrs();
        set_sprite(7, 9'd20, 9'd10, 1'b1, 1'b0, 1'b0, 7'd1, 4'h6);
        for (int i = 0; i < 8; i++) gfx_mem[128 + i] = 8'hFF;
        run_job("clear_only", 9'd10, 1'b0);
    endtask

    task automatic test_basic();
        logic [7:0] want [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h00};
        clear_attrs();
        set_sprite(5, 9'd100, 9'd10, 1'b1, 1'b0, 1'b0, 7'd3, 4'hA);
        for (int i = 0; i < 128; i++) gfx_mem[384 + i] = 8'd0;
        gfx_mem[384] = 8'h12;
        gfx_mem[385] = 8'h30;
        run_job("basic", 9'd10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lbuf[100 + i] !== want[i]) begin
                failures++;
                $display("FAIL basic_x%0d: got %h required %h", 100 + i, lbuf[100 + i], want[i]);
            end
        end
    endtask

    task automatic test_flip();
        logic [7:0] want [4] = '{8'hA2, 8'hA1, 8'h00, 8'hA3};
        clear_attrs();
        set_sprite(5, 9'd100, 9'd10, 1'b1, 1'b1, 1'b1, 7'd3, 4'hA);
        gfx_mem[511] = 8'h12;
        gfx_mem[510] = 8'h30;
        run_job("flip", 9'd10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lbuf[100 + i] !== want[i]) begin
                failures++;
                $display("FAIL flip_x%0d: got %h required %h", 100 + i, lbuf[100 + i], want[i]);
            end
        end
    endtask

    task automatic test_priority();
        clear_attrs();
        for (int i = 0; i < 128; i++) gfx_mem[128 + i] = 8'hFF;
        set_sprite(1, 9'd50, 9'd40, 1'b1, 1'b0, 1'b0, 7'd1, 4'h2);
        set_sprite(0, 9'd50, 9'd40, 1'b1, 1'b0, 1'b0, 7'd1, 4'h1);
        run_job("priority", 9'd40, 1'b1);
        checks++;
        if (lbuf[50] !== 8'h1F) begin
            failures++;
            $display("FAIL priority_x50: got %h required 1f", lbuf[50]);
        end
    endtask

    task automatic setup_overflow();
        clear_attrs();
        for (int i = 0; i < 128; i++) gfx_mem[256 + i] = 8'h77;
        for (int s = 127; s >= 111; s--)
            set_sprite(s, 9'((127 - s) * 16), 9'd20, 1'b1, 1'b0, 1'b0, 7'd2, 4'h3);
    endtask

    task automatic test_overflow();
        setup_overflow();
        run_job("overflow17", 9'd20, 1'b1);
        checks++;
        if (lbuf[240] !== 8'h37 || lbuf[256] !== 8'h00) begin
            failures++;
            $display("FAIL overflow_draw: x240=%h x256=%h required 37 and 00", lbuf[240], lbuf[256]);
        end
        clear_attrs();
        set_sprite(9, 9'd30, 9'd20, 1'b1, 1'b0, 1'b0, 7'd2, 4'h4);
        set_sprite(8, 9'd90, 9'd25, 1'b1, 1'b0, 1'b0, 7'd2, 4'h5);
        run_job("overflow_clears", 9'd20, 1'b1);
    endtask

    task automatic test_edges();
        for (int rr = 0; rr < 16; rr++)
            for (int bb = 0; bb < 8; bb++)
                gfx_mem[768 + rr*8 + bb] = {4'((2*bb) % 15 + 1), 4'((2*bb + 1) % 15 + 1)};
        clear_attrs();
        set_sprite(10, 9'd310, 9'd30, 1'b1, 1'b0, 1'b0, 7'd6, 4'hC);
        run_job("right_edge", 9'd30, 1'b1);
        checks++;
        if (lbuf[310] !== 8'hC1 || lbuf[319] !== 8'hCA) begin
            failures++;
            $display("FAIL right_edge_px: x310=%h x319=%h required c1 and ca", lbuf[310], lbuf[319]);
        end
        clear_attrs();
        set_sprite(10, 9'd505, 9'd505, 1'b1, 1'b0, 1'b0, 7'd6, 4'hD);
        run_job("wrap", 9'd0, 1'b1);
        checks++;
        if (lbuf[0] !== 8'hD8 || lbuf[8] !== 8'hD1 || lbuf[9] !== 8'h00) begin
            failures++;
            $display("FAIL wrap_px: x0=%h x8=%h x9=%h required d8 d1 00", lbuf[0], lbuf[8], lbuf[9]);
        end
    endtask

    task automatic test_random();
        logic [8:0] ln;
        for (int i = 0; i < 16384; i++) gfx_mem[i] = 8'($urandom);
        for (int it = 0; it < 4; it++) begin
            clear_attrs();
            ln = 9'($urandom_range(0, 511));
            for (int s = 0; s < 128; s++) begin
                if ($urandom_range(0, 5) == 0)
                    set_sprite(s, 9'($urandom_range(0, 511)),
                               9'(int'(ln) - int'($urandom_range(0, 20)) + 512),
                               1'b1, 1'($urandom), 1'($urandom),
                               7'($urandom), 4'($urandom));
            end
            run_job($sformatf("random%0d", it), ln, 1'b1);
        end
    endtask

    task automatic test_back_to_back_abort();
        int wr0, dn0, bad0;
        setup_overflow();
        set_sprite(3, 9'd200, 9'd100, 1'b1, 1'b0, 1'b1, 7'd2, 4'h9);
        run_job("abort_prep", 9'd20, 1'b1);
        job_id++;
        start_job(9'd20, 1'b1);
        repeat (800) @(negedge clk);
        #1;
        build_model(9'd100, 1'b1);
        job_id++;
        wr0  = wr_total;
        dn0  = done_total;
        bad0 = bad_total;
        line_num   = 9'd100;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_hold: overflow=%b busy=%b required 1 and 1", overflow, busy);
        end
        wait_done("abort");
        check_job("abort", wr0, dn0, bad0);
    endtask

    task automatic test_reset_mid();
        int wr0, c;
        clear_attrs();
        set_sprite(2, 9'd60, 9'd70, 1'b1, 1'b0, 1'b0, 7'd2, 4'h5);
        for (int i = 0; i < 128; i++) gfx_mem[256 + i] = 8'h77;
        job_id++;
        wr0 = wr_total;
        start_job(9'd70, 1'b1);
        c = 0;
        while (wr_total - wr0 <= 320 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (wr_total - wr0 <= 320) begin
            failures++;
            $display("FAIL reset_mid_reach_draw: writes=%0d required >320", wr_total - wr0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, lb_we, done, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_outputs: busy=%b we=%b done=%b ovf=%b required 0000",
                     busy, lb_we, done, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_job("after_reset", 9'd70, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        line_start = 1'b0;
        line_num   = 9'd0;
        sprites_en = 1'b0;
        clear_attrs();
        for (int i = 0; i < 16384; i++) gfx_mem[i] = 8'd0;
        for (int i = 0; i < 512; i++) begin
            lbuf[i]     = 8'hEE;
            lb_epoch[i] = -1;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_clear_only();
        test_basic();
        test_flip();
        test_priority();
        test_overflow();
        test_edges();
        test_back_to_back_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
